spi_nor_responder: RTL and testbench

Synthesizable SPI NOR flash responder: the slave end of the flash bus (`fMclk`, `fChipSel`, `fMosi`, `fMiso`) that the flash controller drives. It oversamples the SPI pins in the `crystalClk` domain, decodes a command subset (JEDEC ID, status, write enable/disable, read, page program) and serves a small flop-based memory. It sits in the on-board loopback test build in place of the external flash, so controller regressions can run without the physical part.

---
 rtl/spi_nor_pkg.sv | 19 +
 rtl/spi_pin_sync.sv | 39 +++
 rtl/spi_nor_responder.sv | 145 ++++++++++++++
 tb/tb_spi_nor_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_nor_pkg.sv
// spi_nor_pkg: opcodes and FSM state encoding shared by the SPI NOR responder and its controller
package spi_nor_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_PROG,
    ST_STAT,
    ST_ID,
    ST_IGNORE
  } spiState_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-FF synchronizers for the SPI pins plus SCK rise/fall and CS rise strobes
module spi_pin_sync (
  input  logic crystalClk,
  input  logic rstN,
  input  logic fMclk,
  input  logic fChipSel,
  input  logic fMosi,
  output logic sckRise,
  output logic sckFall,
  output logic csHigh,
  output logic csRise,
  output logic mosi
);
  logic [1:0] mclkS, csS, mosiS;
  logic mclkD, csD;
  always_ff @(posedge crystalClk or negedge rstN) begin
    if (!rstN) begin
      mclkS   <= '0;
      csS     <= '0;
      mosiS   <= '0;
      mclkD   <= 1'b0;
      csD     <= 1'b0;
      sckRise <= 1'b0;
      sckFall <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      mclkS   <= {mclkS[0], fMclk};
      csS     <= {csS[0], fChipSel};
      mosiS   <= {mosiS[0], fMosi};
      mclkD   <= mclkS[1];
      csD     <= csS[1];
      sckRise <= mclkS[1] & ~mclkD;
      sckFall <= ~mclkS[1] & mclkD;
      mosi    <= mosiS[1];
    end
  end
  assign csHigh = csS[1];
  assign csRise = csS[1] & ~csD;
endmodule

// File: rtl/spi_nor_responder.sv
// spi_nor_responder: SPI NOR flash slave model with a flop memory, oversampled in the crystalClk domain
module spi_nor_responder
  import spi_nor_pkg::*;
#(
  parameter int          MEM_AW           = 6,
  parameter logic [23:0] JEDEC_ID         = 24'hEF4016,
  parameter int          PROG_BUSY_CYCLES = 64
) (
  input  logic       crystalClk,
  input  logic       rstN,
  input  logic       fMclk,
  input  logic       fChipSel,
  input  logic       fMosi,
  output logic       fMiso,
  output logic       fMisoOe,
  output logic       wip,
  output logic       wel,
  output logic [7:0] lastCmd
);
  localparam int BW = $clog2(PROG_BUSY_CYCLES + 1);
  logic sckRise, sckFall, csHigh, csRise, mosi;
  spiState_t state;
  logic armed, cmdDone, progWrote, isRead;
  logic [6:0] shiftIn;
  logic [7:0] shiftOut, rxByte, statByte, idByte, nextTx;
  logic [4:0] bitCnt;
  logic [2:0] txCnt;
  logic [1:0] idIdx;
  logic [MEM_AW-1:0] addr, addrNext, addrInc;
  logic [BW-1:0] busyCnt;
  logic [7:0] mem [2**MEM_AW];
  spi_pin_sync u_sync (
    .crystalClk(crystalClk),
    .rstN(rstN),
    .fMclk(fMclk),
    .fChipSel(fChipSel),
    .fMosi(fMosi),
    .sckRise(sckRise),
    .sckFall(sckFall),
    .csHigh(csHigh),
    .csRise(csRise),
    .mosi(mosi)
  );
  assign rxByte   = {shiftIn, mosi};
  assign addrNext = {addr[MEM_AW-2:0], mosi};
  assign addrInc  = addr + 1'b1;
  assign statByte = {6'b0, wel, wip};
  assign idByte   = idIdx == 2'd1 ? JEDEC_ID[15:8] : idIdx == 2'd2 ? JEDEC_ID[7:0] : 8'hFF;
  assign nextTx   = state == ST_READ ? mem[addrInc] : state == ST_STAT ? statByte : idByte;
  always_ff @(posedge crystalClk or negedge rstN) begin
    if (!rstN) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      cmdDone   <= 1'b0;
      progWrote <= 1'b0;
      isRead    <= 1'b0;
      shiftIn   <= '0;
      shiftOut  <= '0;
      bitCnt    <= '0;
      txCnt     <= '0;
      idIdx     <= '0;
      addr      <= '0;
      busyCnt   <= '0;
      fMiso     <= 1'b0;
      fMisoOe   <= 1'b0;
      wip       <= 1'b0;
      wel       <= 1'b0;
      lastCmd   <= '0;
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= 8'hFF;
    end else begin
      if (wip) begin
        busyCnt <= busyCnt - 1'b1;
        if (busyCnt == BW'(1)) wip <= 1'b0;
      end
      // end-of-transfer side effects use the state the transfer finished in
      if (csRise && cmdDone && lastCmd == CMD_WREN && !wip) wel <= 1'b1;
      if (csRise && cmdDone && lastCmd == CMD_WRDI) wel <= 1'b0;
      if (csRise && state == ST_PROG && progWrote) begin
        wip     <= 1'b1;
        wel     <= 1'b0;
        busyCnt <= BW'(PROG_BUSY_CYCLES);
      end
      if (csHigh) begin
        state   <= ST_IDLE;
        fMiso   <= 1'b0;
        fMisoOe <= 1'b0;
        armed   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (armed) begin
            state     <= ST_CMD;
            bitCnt    <= '0;
            cmdDone   <= 1'b0;
            progWrote <= 1'b0;
          end
          ST_CMD: if (sckRise) begin
            shiftIn <= rxByte[6:0];
            bitCnt  <= bitCnt + 1'b1;
            if (bitCnt[2:0] == 3'd7) begin
              lastCmd  <= rxByte;
              cmdDone  <= 1'b1;
              bitCnt   <= '0;
              txCnt    <= '0;
              idIdx    <= 2'd1;
              isRead   <= rxByte == CMD_READ;
              shiftOut <= rxByte == CMD_RDSR ? statByte : JEDEC_ID[23:16];
              state    <= (rxByte == CMD_READ || rxByte == CMD_PP) ? ST_ADDR :
                          rxByte == CMD_RDSR ? ST_STAT :
                          rxByte == CMD_RDID ? ST_ID : ST_IGNORE;
            end
          end
          ST_ADDR: if (sckRise) begin
            addr   <= addrNext;
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == 5'd23) begin
              bitCnt   <= '0;
              shiftOut <= mem[addrNext];
              state    <= isRead ? ST_READ : (wel && !wip) ? ST_PROG : ST_IGNORE;
            end
          end
          ST_PROG: if (sckRise) begin
            shiftIn <= rxByte[6:0];
            bitCnt  <= bitCnt + 1'b1;
            if (bitCnt[2:0] == 3'd7) begin
              mem[addr] <= mem[addr] & rxByte;
              addr      <= addrInc;
              progWrote <= 1'b1;
            end
          end
          ST_READ, ST_STAT, ST_ID: if (sckFall) begin
            fMiso    <= shiftOut[7];
            fMisoOe  <= 1'b1;
            txCnt    <= txCnt + 1'b1;
            shiftOut <= txCnt == 3'd7 ? nextTx : {shiftOut[6:0], 1'b0};
            if (txCnt == 3'd7) begin
              addr  <= state == ST_READ ? addrInc : addr;
              idIdx <= idIdx == 2'd3 ? idIdx : idIdx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_nor_responder.sv
// tb_spi_nor_responder: randomized SPI master with a transaction-level flash model and a MISO scoreboard
module tb_spi_nor_responder;
  localparam int AW = 6;
  localparam int DEPTH = 64;
  localparam int BUSY = 64;
  logic clk = 1'b0, rstN = 1'b0, fMclk = 1'b0, fChipSel = 1'b1, fMosi = 1'b0;
  logic fMiso, fMisoOe, wip, wel;
  logic [7:0] lastCmd;
  int compared = 0, mismatched = 0;
  logic [7:0] expQ[$], txq[$], dq[$];
  logic [7:0] refMem [DEPTH];
  logic refWel = 1'b0;
  int hp = 4;
  bit monEn = 1'b1;
  int wipRun = 0, wipLast = 0;

  spi_nor_responder #(.MEM_AW(AW), .JEDEC_ID(24'hEF4016), .PROG_BUSY_CYCLES(BUSY)) dut (
    .crystalClk(clk),
    .rstN(rstN),
    .fMclk(fMclk),
    .fChipSel(fChipSel),
    .fMosi(fMosi),
    .fMiso(fMiso),
    .fMisoOe(fMisoOe),
    .wip(wip),
    .wel(wel),
    .lastCmd(lastCmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] cur;
    int nb;
    nb = 0;
    cur = '0;
    forever begin
      @(posedge fMclk or posedge fChipSel);
      if (fChipSel || !monEn) nb = 0;
      else if (fMisoOe) begin
        cur = {cur[6:0], fMiso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL miso unexpected byte: got %0h, expected none", cur);
          end else check("miso byte", cur, expQ.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (wip) wipRun++;
    else if (wipRun > 0) begin
      wipLast = wipRun;
      wipRun = 0;
    end
  end

  task automatic xfer(input int nbits);
    @(negedge clk) fChipSel = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      fMosi = (i / 8 < txq.size()) ? txq[i / 8][7 - i % 8] : 1'b0;
      repeat (hp) @(negedge clk);
      fMclk = 1'b1;
      repeat (hp) @(negedge clk);
      fMclk = 1'b0;
    end
    repeat (hp) @(negedge clk);
    fChipSel = 1'b1;
    fMosi = 1'b0;
    repeat (3 * hp) @(negedge clk);
    txq.delete();
  endtask

  task automatic doSimple(input logic [7:0] op);
    txq = {op};
    xfer(8);
    if (op == 8'h06) refWel = 1'b1;
    else if (op == 8'h04) refWel = 1'b0;
    check("cmd lastCmd", lastCmd, op);
    check("cmd wel", wel, refWel);
  endtask

  task automatic doStat(input int n);
    txq = {8'h05};
    for (int k = 0; k < n; k++) expQ.push_back({6'b0, refWel, 1'b0});
    xfer(8 + 8 * n);
    check("rdsr lastCmd", lastCmd, 8'h05);
  endtask

  task automatic doId(input int n);
    logic [23:0] id;
    id = 24'hEF4016;
    txq = {8'h9F};
    for (int k = 0; k < n; k++)
      expQ.push_back(k == 0 ? id[23:16] : k == 1 ? id[15:8] : k == 2 ? id[7:0] : 8'hFF);
    xfer(8 + 8 * n);
    check("rdid lastCmd", lastCmd, 8'h9F);
  endtask

  task automatic doRead(input logic [23:0] a, input int n);
    txq = {8'h03, a[23:16], a[15:8], a[7:0]};
    for (int k = 0; k < n; k++) expQ.push_back(refMem[(a + k) % DEPTH]);
    xfer(32 + 8 * n);
    check("read lastCmd", lastCmd, 8'h03);
  endtask

  task automatic doPp(input logic [23:0] a, input int extra);
    bit ok;
    ok = refWel && dq.size() > 0;
    txq = {8'h02, a[23:16], a[15:8], a[7:0]};
    foreach (dq[k]) txq.push_back(dq[k]);
    if (extra > 0) txq.push_back(8'($urandom));
    if (refWel) foreach (dq[k]) refMem[(a + k) % DEPTH] &= dq[k];
    wipLast = 0;
    xfer(32 + 8 * dq.size() + extra);
    if (ok) refWel = 1'b0;
    check("pp lastCmd", lastCmd, 8'h02);
    check("pp wel", wel, refWel);
    check("pp wip", wip, ok);
    if (ok) begin
      for (int n = 0; n < 500 && wip; n++) @(negedge clk);
      check("wip clears", wip, 1'b0);
      repeat (2) @(negedge clk);
      check("wip length", wipLast, BUSY);
    end
    dq.delete();
  endtask

  initial begin
    logic [7:0] op;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset fMiso", fMiso, 1'b0);
    check("reset fMisoOe", fMisoOe, 1'b0);
    check("reset wip", wip, 1'b0);
    check("reset wel", wel, 1'b0);
    check("reset lastCmd", lastCmd, 8'h00);
    rstN = 1'b1;
    repeat (5) @(negedge clk);

    doId(4);
    doStat(3);
    doSimple(8'h06);
    doStat(3);
    dq = {8'hA5, 8'h3C};
    doPp(24'h000010, 0);
    doRead(24'h000010, 3);
    dq = {8'h00};
    doPp(24'h000000, 0);
    doRead(24'h000000, 1);
    doSimple(8'h06);
    dq = {8'h0F};
    doPp(24'h000010, 0);
    doRead(24'h000010, 1);
    doRead(24'h00003F, 2);
    doRead(24'h100010, 1);
    doSimple(8'h06);
    doPp(24'h000020, 4);
    check("aborted pp wip", wip, 1'b0);
    check("aborted pp wel", wel, 1'b1);
    doRead(24'h000020, 1);

    for (int t = 0; t < 30; t++) begin
      hp = $urandom_range(4, 6);
      case ($urandom_range(0, 7))
        0: doSimple(8'h06);
        1: doSimple(8'h04);
        2: doStat($urandom_range(1, 3));
        3: doId($urandom_range(1, 5));
        4, 5: doRead(24'($urandom), $urandom_range(1, 4));
        6: begin
          repeat ($urandom_range(0, 3)) dq.push_back(8'($urandom));
          if ($urandom_range(0, 1) == 1) doSimple(8'h06);
          doPp(24'($urandom), $urandom_range(0, 1) == 1 ? 0 : $urandom_range(1, 7));
        end
        default: begin
          do op = 8'($urandom);
          while (op inside {8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h9F});
          doSimple(op);
        end
      endcase
    end

    hp = 4;
    doSimple(8'h06);
    monEn = 1'b0;
    txq = {8'h03, 8'h00, 8'h00, 8'h10};
    fork
      xfer(64);
    join_none
    for (int n = 0; n < 2000 && !fMisoOe; n++) @(negedge clk);
    check("oe before reset", fMisoOe, 1'b1);
    repeat (12) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("mid-read reset fMiso", fMiso, 1'b0);
    check("mid-read reset fMisoOe", fMisoOe, 1'b0);
    check("mid-read reset wel", wel, 1'b0);
    check("mid-read reset lastCmd", lastCmd, 8'h00);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    wait fork;
    check("no response after reset fMisoOe", fMisoOe, 1'b0);
    check("no response after reset lastCmd", lastCmd, 8'h00);
    check("leftover expected bytes", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
